// File: rtl/time_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : time_set_ctrl
//  Brief    : Time-setting mode sequencer with hold-to-repeat inc/dec strobes,
//             idle return to RUN. Optional digit blink: TIME_SET_BLINK_EN.
//  Revision : 1.0  initial release
// ============================================================================
module time_set_ctrl #(
    parameter int HOLD_DELAY    = 50000,
    parameter int REPEAT_PERIOD = 10000,
    parameter int IDLE_TIMEOUT  = 1000000,
    parameter int BLINK_HALF    = 25000
) (
    input  logic       clk100khz,
    input  logic       rst,
    input  logic       mode_set,
    input  logic       inc,
    input  logic       dec,
    output logic [1:0] mode_flag,
    output logic       run_en,
    output logic       inc_pulse,
    output logic       dec_pulse,
    output logic [5:0] blink_mask
);
    // The repeat counter folds back to HOLD_DELAY, so its top value is HOLD+REPEAT-1.
    localparam int c_REP_TOP = HOLD_DELAY + REPEAT_PERIOD - 1;
    localparam int c_MAX_A   = (c_REP_TOP > IDLE_TIMEOUT) ? c_REP_TOP : IDLE_TIMEOUT;
    localparam int c_MAX     = (c_MAX_A > BLINK_HALF) ? c_MAX_A : BLINK_HALF;
    localparam int c_CW      = $clog2(c_MAX + 1);

    localparam logic [c_CW-1:0] c_ONE       = c_CW'(1);
    localparam logic [c_CW-1:0] c_HOLD      = c_CW'(HOLD_DELAY);
    localparam logic [c_CW-1:0] c_REP_LAST  = c_CW'(c_REP_TOP);
    localparam logic [c_CW-1:0] c_IDLE_LAST = c_CW'(IDLE_TIMEOUT - 1);

    localparam logic [1:0] c_ST_RUN   = 2'd0;
    localparam logic [1:0] c_ST_SET_H = 2'd1;
    localparam logic [1:0] c_ST_SET_M = 2'd2;
    localparam logic [1:0] c_ST_SET_S = 2'd3;

    logic [1:0]      r_state;
    logic            r_mode_prev;
    logic            r_inc_prev;
    logic            r_dec_prev;
    logic [c_CW-1:0] r_rep_cnt;
    logic            r_arm_inc;
    logic            r_arm_dec;
    logic [c_CW-1:0] r_idle_cnt;
    logic            r_run_en;
    logic            r_inc_pulse;
    logic            r_dec_pulse;

    logic            w_mode_edge;
    logic            w_inc_edge;
    logic            w_dec_edge;
    logic            w_inc_only;
    logic            w_dec_only;
    logic            w_key_edge;
    logic            w_in_set;
    logic            w_activity;
    logic [1:0]      w_state_nxt;
    logic            w_inc_strobe;
    logic            w_dec_strobe;
    logic [c_CW-1:0] w_rep_nxt;
    logic            w_arm_inc_nxt;
    logic            w_arm_dec_nxt;
    logic [c_CW-1:0] w_idle_nxt;

    assign w_mode_edge = mode_set & ~r_mode_prev;
    assign w_inc_edge  = inc & ~r_inc_prev;
    assign w_dec_edge  = dec & ~r_dec_prev;
    assign w_inc_only  = inc & ~dec;
    assign w_dec_only  = dec & ~inc;
    assign w_key_edge  = w_inc_only ? w_inc_edge : w_dec_edge;
    assign w_in_set    = (r_state != c_ST_RUN);
    assign w_activity  = w_mode_edge | w_inc_edge | w_dec_edge | w_inc_strobe | w_dec_strobe;

    always_comb begin
        w_state_nxt   = r_state;
        w_inc_strobe  = 1'b0;
        w_dec_strobe  = 1'b0;
        w_rep_nxt     = '0;
        w_arm_inc_nxt = 1'b0;
        w_arm_dec_nxt = 1'b0;
        w_idle_nxt    = '0;

        // Repeat only runs after a fresh edge of a key that is pressed alone.
        if (w_in_set && !w_mode_edge && (w_inc_only || w_dec_only)) begin
            if (w_key_edge) begin
                w_rep_nxt     = c_ONE;
                w_inc_strobe  = w_inc_only;
                w_dec_strobe  = w_dec_only;
                w_arm_inc_nxt = w_inc_only;
                w_arm_dec_nxt = w_dec_only;
            end else if ((w_inc_only && r_arm_inc) || (w_dec_only && r_arm_dec)) begin
                w_arm_inc_nxt = w_inc_only;
                w_arm_dec_nxt = w_dec_only;
                w_rep_nxt     = (r_rep_cnt == c_REP_LAST) ? c_HOLD : r_rep_cnt + c_ONE;
                if (r_rep_cnt == c_HOLD) begin
                    w_inc_strobe = w_inc_only;
                    w_dec_strobe = w_dec_only;
                end
            end
        end

        if (w_mode_edge) begin
            case (r_state)
                c_ST_RUN:   w_state_nxt = c_ST_SET_H;
                c_ST_SET_H: w_state_nxt = c_ST_SET_M;
                c_ST_SET_M: w_state_nxt = c_ST_SET_S;
                default:    w_state_nxt = c_ST_RUN;
            endcase
        end else if (w_in_set && !w_activity && (r_idle_cnt == c_IDLE_LAST)) begin
            w_state_nxt = c_ST_RUN;
        end

        if (w_in_set && !w_activity && (w_state_nxt == r_state)) begin
            w_idle_nxt = r_idle_cnt + c_ONE;
        end
    end

    always_ff @(posedge clk100khz) begin
        if (rst) begin
            r_state     <= c_ST_RUN;
            r_mode_prev <= 1'b0;
            r_inc_prev  <= 1'b0;
            r_dec_prev  <= 1'b0;
            r_rep_cnt   <= '0;
            r_arm_inc   <= 1'b0;
            r_arm_dec   <= 1'b0;
            r_idle_cnt  <= '0;
            r_run_en    <= 1'b1;
            r_inc_pulse <= 1'b0;
            r_dec_pulse <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_mode_prev <= mode_set;
            r_inc_prev  <= inc;
            r_dec_prev  <= dec;
            r_rep_cnt   <= w_rep_nxt;
            r_arm_inc   <= w_arm_inc_nxt;
            r_arm_dec   <= w_arm_dec_nxt;
            r_idle_cnt  <= w_idle_nxt;
            r_run_en    <= (w_state_nxt == c_ST_RUN);
            r_inc_pulse <= w_inc_strobe;
            r_dec_pulse <= w_dec_strobe;
        end
    end

    assign mode_flag = r_state;
    assign run_en    = r_run_en;
    assign inc_pulse = r_inc_pulse;
    assign dec_pulse = r_dec_pulse;

`ifdef TIME_SET_BLINK_EN
    localparam logic [c_CW-1:0] c_BLINK_LAST = c_CW'(BLINK_HALF - 1);

    logic [c_CW-1:0] r_blink_cnt;
    logic            r_blink_on;

    // Phase restarts visible on any mode change or strobe so a new value is shown at once.
    always_ff @(posedge clk100khz) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if ((w_state_nxt == c_ST_RUN) || (w_state_nxt != r_state) ||
                     w_inc_strobe || w_dec_strobe) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (r_blink_cnt == c_BLINK_LAST) begin
            r_blink_cnt <= '0;
            r_blink_on  <= ~r_blink_on;
        end else begin
            r_blink_cnt <= r_blink_cnt + c_ONE;
        end
    end

    always_comb begin
        blink_mask = 6'b111111;
        if (!r_blink_on) begin
            case (r_state)
                c_ST_SET_H: blink_mask[5:4] = 2'b00;
                c_ST_SET_M: blink_mask[3:2] = 2'b00;
                c_ST_SET_S: blink_mask[1:0] = 2'b00;
                default:    blink_mask      = 6'b111111;
            endcase
        end
    end
`else
    assign blink_mask = 6'b111111;
`endif

endmodule
`default_nettype wire

// File: tb/tb_time_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_time_set_ctrl
//  Brief    : Directed, table-driven self-checking bench for time_set_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_time_set_ctrl;
    localparam int c_HOLD   = 8;
    localparam int c_REP    = 4;
    localparam int c_IDLE   = 40;
    localparam int c_BLINKH = 5;
`ifdef TIME_SET_BLINK_EN
    localparam bit c_BLINK = 1'b1;
`else
    localparam bit c_BLINK = 1'b0;
`endif

    typedef struct packed {
        logic       ms;
        logic       i;
        logic       d;
        logic [1:0] mode;
        logic       ip;
        logic       dp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode_set;
    logic       inc;
    logic       dec;
    logic [1:0] mode_flag;
    logic       run_en;
    logic       inc_pulse;
    logic       dec_pulse;
    logic [5:0] blink_mask;

    int   checks = 0;
    int   errors = 0;
    vec_t tbl [22];

    always #5 clk = ~clk;

    time_set_ctrl #(
        .HOLD_DELAY    (c_HOLD),
        .REPEAT_PERIOD (c_REP),
        .IDLE_TIMEOUT  (c_IDLE),
        .BLINK_HALF    (c_BLINKH)
    ) dut (
        .clk100khz  (clk),
        .rst        (rst),
        .mode_set   (mode_set),
        .inc        (inc),
        .dec        (dec),
        .mode_flag  (mode_flag),
        .run_en     (run_en),
        .inc_pulse  (inc_pulse),
        .dec_pulse  (dec_pulse),
        .blink_mask (blink_mask)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic ms, input logic i, input logic d);
        mode_set = ms;
        inc      = i;
        dec      = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string name, input int m, input logic ip, input logic dp);
        check({name, ".mode"}, 32'(mode_flag), 32'(m));
        check({name, ".run_en"}, 32'(run_en), 32'(m == 0));
        check({name, ".inc_pulse"}, 32'(inc_pulse), 32'(ip));
        check({name, ".dec_pulse"}, 32'(dec_pulse), 32'(dp));
        if (!c_BLINK || m == 0) check({name, ".mask"}, 32'(blink_mask), 32'h3F);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int n;
        int r;
        logic [5:0] exp_mask;

        tbl = '{
            '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0},  // RUN: inc ignored
            '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0},  // RUN: dec ignored
            '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0},
            '{1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0},  // -> SET_H
            '{1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0},  // both keys: nothing
            '{1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0},  // drop inc, dec held: no edge
            '{1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1},  // fresh dec edge
            '{1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0},
            '{1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0},  // mode and inc edge together
            '{1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0},
            '{1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0},
            '{1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0},  // mode and dec edge together
            '{1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0},
            '{1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0},  // -> RUN
            '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0}
        };

        // Reset state
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check_outs("reset", 0, 1'b0, 1'b0);
        check("reset.mask", 32'(blink_mask), 32'h3F);
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0);

        // Mode cycling, presses 20 cycles apart
        for (int p = 0; p < 4; p++) begin
            step(1'b1, 1'b0, 1'b0);
            check_outs("t1_press", (p + 1) % 4, 1'b0, 1'b0);
            for (int k = 1; k < 20; k++) begin
                step(1'b0, 1'b0, 1'b0);
                check_outs("t1_stay", (p + 1) % 4, 1'b0, 1'b0);
            end
        end

        // Table of priority / ignore / both-key cases
        for (int v = 0; v < 22; v++) begin
            step(tbl[v].ms, tbl[v].i, tbl[v].d);
            check_outs($sformatf("tbl[%0d]", v), int'(tbl[v].mode), tbl[v].ip, tbl[v].dp);
        end

        // Hold-to-repeat in SET_M
        step(1'b1, 1'b0, 1'b0); check_outs("t2_enter_h", 1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0); check_outs("t2_enter_m", 2, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b1, 1'b0);
            check_outs("t2_hold", 2, (k == 0 || k == 8 || k == 12 || k == 16), 1'b0);
            if (inc_pulse === 1'b1) n++;
        end
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b0, 1'b0);
            check_outs("t2_release", 2, 1'b0, 1'b0);
        end
        check("t2_count", 32'(n), 32'd4);
        step(1'b1, 1'b0, 1'b0); check_outs("t2_exit_s", 3, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0); check_outs("t2_exit_run", 0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // Idle timeout, then timeout deferred by a strobe at cycle 30
        for (int pass = 0; pass < 2; pass++) begin
            for (int p = 1; p <= 2; p++) begin
                step(1'b1, 1'b0, 1'b0); check_outs("t4_enter", p, 1'b0, 1'b0);
                step(1'b0, 1'b0, 1'b0);
            end
            step(1'b1, 1'b0, 1'b0); check_outs("t4_enter_s", 3, 1'b0, 1'b0);
            for (int k = 1; k <= 75; k++) begin
                step(1'b0, (pass == 1 && k == 30), 1'b0);
                if (pass == 0) check_outs("t4_idle", (k < 40) ? 3 : 0, 1'b0, 1'b0);
                else check_outs("t4_defer", (k < 70) ? 3 : 0, (k == 30), 1'b0);
            end
        end

        // Reset asserted while auto-repeat is active
        step(1'b1, 1'b0, 1'b0); check_outs("t5_enter", 1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b1, 1'b0);
            check_outs("t5_hold", 1, (k == 0 || k == 8), 1'b0);
        end
        rst = 1'b1;
        step(1'b0, 1'b1, 1'b0);
        check_outs("t5_in_reset", 0, 1'b0, 1'b0);
        check("t5_reset.mask", 32'(blink_mask), 32'h3F);
        rst = 1'b0;
        step(1'b0, 1'b1, 1'b0);
        check_outs("t5_after_reset", 0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check_outs("t5_idle", 0, 1'b0, 1'b0);

        // Digit blink in SET_H (constant mask when the feature is off)
        step(1'b1, 1'b0, 1'b0); check_outs("t6_enter", 1, 1'b0, 1'b0);
        check("t6_mask0", 32'(blink_mask), 32'h3F);
        r = 0;
        for (int k = 1; k <= 16; k++) begin
            step(1'b0, (k == 7), 1'b0);
            if (k == 7) r = 7;
            exp_mask = (!c_BLINK || (((k - r) / c_BLINKH) % 2 == 0)) ? 6'h3F : 6'h0F;
            check("t6_mask", 32'(blink_mask), 32'(exp_mask));
            check("t6_inc_pulse", 32'(inc_pulse), 32'(k == 7));
        end
        step(1'b1, 1'b0, 1'b0); check_outs("t6_m", 2, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0); check_outs("t6_s", 3, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0); check_outs("t6_run", 0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
